alu_cmp_seq: RTL and testbench

//   Multi-cycle signed compare engine for the Beta ALU CMPxx ops. It computes a-b on a

---
 rtl/alu_cmp_seq_if.sv | 27 ++
 rtl/alu_cmp_seq.sv | 140 ++++++++++++++
 tb/tb_alu_cmp_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmp_seq_if.sv
// Handshake and operand/result bundle for the sliced compare engine.
// The issue side drives operands and consumes results as master.
interface alu_cmp_seq_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   cfn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         z;
  logic         n;
  logic         v;

  modport master (
    output in_valid, a, b, cfn, out_ready,
    input  in_ready, out_valid, y, z, n, v
  );

  modport slave (
    input  in_valid, a, b, cfn, out_ready,
    output in_ready, out_valid, y, z, n, v
  );
endinterface

// File: rtl/alu_cmp_seq.sv
// Multi-cycle signed compare for the Beta CMPxx ops: a-b on a narrow subtractor,
// LSB slice first, with Z/N/V accumulated and reduced through the cfn select.
module alu_cmp_seq #(
  parameter int W       = 32,
  parameter int SLICE_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  alu_cmp_seq_if.slave bus
);

  localparam int NSLICE = W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic               a_msb;
  logic               b_msb;
  logic [1:0]         cfn_r;
  logic               carry;
  logic               zacc;
  logic [IDX_W-1:0]   idx;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [W-1:0]       y_q;
  logic               z_q;
  logic               n_q;
  logic               v_q;

  logic [SLICE_W:0]   sum;
  logic               z_final;
  logic               d_msb;
  logic               v_final;
  logic               cmp;
  logic               last;

  // Operands are shifted right each cycle so the subtractor always sees the low slice;
  // the signs are kept separately for the overflow term.
  always_comb begin
    sum     = {1'b0, a_sh[SLICE_W-1:0]} + {1'b0, ~b_sh[SLICE_W-1:0]}
            + {{SLICE_W{1'b0}}, carry};
    z_final = zacc & (sum[SLICE_W-1:0] == '0);
    d_msb   = sum[SLICE_W-1];
    v_final = (a_msb != b_msb) & (d_msb != a_msb);
    last    = (idx == IDX_W'(NSLICE - 1));
    case (cfn_r)
      2'b01:   cmp = z_final;
      2'b10:   cmp = d_msb ^ v_final;
      2'b11:   cmp = z_final | (d_msb ^ v_final);
      default: cmp = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
      cfn_r       <= 2'b00;
      carry       <= 1'b1;
      zacc        <= 1'b1;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
    end else if (flush) begin
      // Result registers are left untouched; out_valid gates their use.
      state       <= IDLE;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh       <= bus.a;
            b_sh       <= bus.b;
            a_msb      <= bus.a[W-1];
            b_msb      <= bus.b[W-1];
            cfn_r      <= bus.cfn;
            carry      <= 1'b1;
            zacc       <= 1'b1;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          carry <= sum[SLICE_W];
          zacc  <= z_final;
          idx   <= idx + 1'b1;
          a_sh  <= a_sh >> SLICE_W;
          b_sh  <= b_sh >> SLICE_W;
          if (last) begin
            n_q         <= d_msb;
            z_q         <= z_final;
            v_q         <= v_final;
            y_q         <= {{(W-1){1'b0}}, cmp};
            idx         <= '0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;
  assign bus.v         = v_q;

endmodule

// File: tb/tb_alu_cmp_seq.sv
// Directed plus randomized check of alu_cmp_seq against a plain-arithmetic
// signed-compare reference.
module tb_alu_cmp_seq;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  alu_cmp_seq_if #(.W(32)) ifc ();

  alu_cmp_seq #(.W(32), .SLICE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference: wide signed subtraction and native signed compares.
  function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                   input logic [1:0] cfn, output logic [31:0] y,
                                   output logic z, output logic n, output logic v);
    logic signed [32:0] d;
    logic               lt;
    d  = $signed({a[31], a}) - $signed({b[31], b});
    z  = (a == b);
    n  = d[31];
    v  = (d[32] != d[31]);
    lt = ($signed(a) < $signed(b));
    case (cfn)
      2'b01:   y = {31'b0, z};
      2'b10:   y = {31'b0, lt};
      2'b11:   y = {31'b0, lt | z};
      default: y = 32'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cfn);
    checkOutput("in_ready_idle", {31'b0, ifc.in_ready}, 32'd1);
    ifc.a        = a;
    ifc.b        = b;
    ifc.cfn      = cfn;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    checkOutput("accepted", {31'b0, ifc.in_ready}, 32'd0);
  endtask

  // Operand bus is scrambled while waiting: the engine must ignore it.
  task automatic waitResult(input string tag);
    int edges;
    edges = 0;
    while (!ifc.out_valid && edges < 20) begin
      ifc.a   = $urandom;
      ifc.b   = $urandom;
      ifc.cfn = 2'($urandom);
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'd4);
  endtask

  task automatic checkResult(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] cfn);
    logic [31:0] ey;
    logic        ez, en, ev;
    refModel(a, b, cfn, ey, ez, en, ev);
    checkOutput({tag, "_y"}, ifc.y, ey);
    checkOutput({tag, "_z"}, {31'b0, ifc.z}, {31'b0, ez});
    checkOutput({tag, "_n"}, {31'b0, ifc.n}, {31'b0, en});
    checkOutput({tag, "_v"}, {31'b0, ifc.v}, {31'b0, ev});
  endtask

  task automatic consume(input string tag);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    checkOutput({tag, "_ov_drop"}, {31'b0, ifc.out_valid}, 32'd0);
    checkOutput({tag, "_rdy_back"}, {31'b0, ifc.in_ready}, 32'd1);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] cfn);
    applyStimulus(a, b, cfn);
    waitResult(tag);
    checkResult(tag, a, b, cfn);
    consume(tag);
  endtask

  initial begin
    logic [31:0] ra, rb, hold_y;
    logic [1:0]  rc;

    reset         = 1'b1;
    flush         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.a         = '0;
    ifc.b         = '0;
    ifc.cfn       = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
    checkOutput("rst_y", ifc.y, 32'd0);
    checkOutput("rst_flags", {29'b0, ifc.z, ifc.n, ifc.v}, 32'd0);

    runOp("eq_equal", 32'd5, 32'd5, 2'b01);
    checkOutput("eq_equal_y_const", ifc.y, 32'd1);
    runOp("lt_min", 32'h8000_0000, 32'd1, 2'b10);
    runOp("le_ovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b11);
    runOp("eq_hislice", 32'h0000_0100, 32'd0, 2'b01);

    // Result held under backpressure while a new request is offered.
    applyStimulus(32'd9, 32'd2, 2'b11);
    waitResult("stall");
    hold_y = ifc.y;
    checkResult("stall", 32'd9, 32'd2, 2'b11);
    ifc.a        = 32'd1;
    ifc.b        = 32'd1;
    ifc.cfn      = 2'b01;
    ifc.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_ov", {31'b0, ifc.out_valid}, 32'd1);
      checkOutput("stall_in_ready", {31'b0, ifc.in_ready}, 32'd0);
      checkOutput("stall_y", ifc.y, hold_y);
    end
    checkResult("stall_hold", 32'd9, 32'd2, 2'b11);
    ifc.in_valid = 1'b0;
    consume("stall");
    @(posedge clk);
    #1;
    checkOutput("stall_no_accept", {31'b0, ifc.in_ready}, 32'd1);

    // Flush after two slices.
    applyStimulus(32'd3, 32'd3, 2'b01);
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_in_ready", {31'b0, ifc.in_ready}, 32'd1);
    checkOutput("flush_ov", {31'b0, ifc.out_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      checkOutput("flush_ov_quiet", {31'b0, ifc.out_valid}, 32'd0);
    end
    runOp("after_flush", 32'd3, 32'd7, 2'b10);
    checkOutput("after_flush_y_const", ifc.y, 32'd1);

    // Flush beats in_valid in IDLE.
    ifc.a        = 32'd4;
    ifc.b        = 32'd4;
    ifc.cfn      = 2'b01;
    ifc.in_valid = 1'b1;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    flush        = 1'b0;
    checkOutput("flush_vs_valid", {31'b0, ifc.in_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("flush_vs_valid_ov", {31'b0, ifc.out_valid}, 32'd0);
    end

    // Reset while a result is pending.
    applyStimulus(32'd1, 32'd2, 2'b11);
    waitResult("rst_done");
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_done_ov", {31'b0, ifc.out_valid}, 32'd0);
    checkOutput("rst_done_y", ifc.y, 32'd0);
    checkOutput("rst_done_flags", {29'b0, ifc.z, ifc.n, ifc.v}, 32'd0);
    checkOutput("rst_done_in_ready", {31'b0, ifc.in_ready}, 32'd1);

    runOp("cfn_zero", $urandom, $urandom, 2'b00);
    checkOutput("cfn_zero_y_const", ifc.y, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra + 32'd1;
        2:       rb = {ra[31:8], 8'($urandom)};
        default: rb = $urandom;
      endcase
      rc = 2'($urandom);
      runOp("rand", ra, rb, rc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
